st_bus_tx: RTL and testbench

ST-BUS timing master and serial transmitter. It derives the C4 bit clock (4.096 MHz) and the active-low F0 frame pulse (8 kHz) from the system clock, and shifts 32 eight-bit channels per frame onto a 2.048 Mb/s serial line. It is the driving end for the converter blocks that consume `f0`/`c4` and count bits into channels. Byte data enters over a ready/valid port, one channel ahead of transmission.

---
 rtl/st_bus_pkg.sv | 8 +
 rtl/st_bus_timing.sv | 57 +++++
 rtl/st_bus_tx.sv | 74 +++++++
 tb/tb_st_bus_tx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/st_bus_pkg.sv
// st_bus_pkg: shared ST-BUS frame constants and channel type
package st_bus_pkg;
  localparam int FRAME_C4 = 512;
  localparam int CHANNELS = 32;
  localparam int BITS_PER_CH = 8;
  localparam logic [BITS_PER_CH-1:0] IDLE_BYTE = 8'hFF;
  typedef logic [4:0] ch_t;
endpackage

// File: rtl/st_bus_timing.sv
// st_bus_timing: C4/F0 generation plus bit-boundary and load strobes
module st_bus_timing
  import st_bus_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_c4,
  output logic o_f0,
  output logic o_frame_start,
  output logic o_bit,
  output logic o_load,
  output ch_t  o_ch
);
  localparam int DW = $clog2(DIV);
  localparam int CW = $clog2(FRAME_C4);
  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_c4;
  logic          r_f0;
  logic          r_fs;
  logic          w_div_end;
  logic          w_wrap;
  // next counter values; a low enable parks both counters at the frame start
  always_comb begin
    w_div_end = r_div == DW'(DIV - 1);
    w_wrap    = w_div_end && r_cnt == CW'(FRAME_C4 - 1);
    w_div_nxt = (!i_en || w_div_end) ? '0 : r_div + DW'(1);
    w_cnt_nxt = !i_en ? '0 : r_cnt + CW'(w_div_end);
  end
  // c4/f0 are registered from the next counter state so they line up with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_cnt <= '0;
      r_c4  <= 1'b1;
      r_f0  <= 1'b1;
      r_fs  <= 1'b0;
    end else begin
      r_div <= w_div_nxt;
      r_cnt <= w_cnt_nxt;
      r_c4  <= w_div_nxt < DW'(DIV / 2);
      r_f0  <= w_cnt_nxt != CW'(FRAME_C4 - 1);
      r_fs  <= i_en && w_wrap;
    end
  end
  assign o_c4          = r_c4;
  assign o_f0          = r_f0;
  assign o_frame_start = r_fs;
  assign o_bit         = i_en && w_div_end && r_cnt[0];
  assign o_load        = i_en && w_div_end && (&r_cnt[3:0]);
  assign o_ch          = r_cnt[CW-1 -: 5];
endmodule

// File: rtl/st_bus_tx.sv
// st_bus_tx: ST-BUS timing master with a one-byte holding stage and serial shifter
module st_bus_tx
  import st_bus_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [BITS_PER_CH-1:0] ch_data,
  input  logic                   ch_valid,
  output logic                   ch_ready,
  output ch_t                    ch_num,
  output logic                   c4,
  output logic                   f0,
  output logic                   dstx,
  output logic                   frame_start,
  output logic                   underrun
);
  logic                   r_run;
  logic                   r_full;
  logic [BITS_PER_CH-1:0] r_hold;
  logic [BITS_PER_CH-1:0] r_shift;
  logic                   w_run;
  logic                   w_bit;
  logic                   w_load;
  logic                   w_accept;
  ch_t                    w_ch;
  st_bus_timing #(.DIV(DIV)) u_timing (
    .clk           (clk),
    .reset         (reset),
    .i_en          (en),
    .o_c4          (c4),
    .o_f0          (f0),
    .o_frame_start (frame_start),
    .o_bit         (w_bit),
    .o_load        (w_load),
    .o_ch          (w_ch)
  );
  // handshake and status; r_run keeps them idle until the first edge out of reset
  always_comb begin
    w_run    = en && r_run;
    ch_ready = w_run && !r_full && !w_load;
    w_accept = ch_valid && ch_ready;
    ch_num   = w_run ? ch_t'((int'(w_ch) + 1) % CHANNELS) : '0;
    underrun = w_run && w_load && !r_full;
    dstx     = r_shift[BITS_PER_CH-1];
  end
  // holding/shift pipeline: load wins over shift, accepts never land on a load cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run   <= 1'b0;
      r_full  <= 1'b0;
      r_hold  <= IDLE_BYTE;
      r_shift <= IDLE_BYTE;
    end else if (!en) begin
      r_run   <= 1'b0;
      r_full  <= 1'b0;
      r_shift <= IDLE_BYTE;
    end else begin
      r_run <= 1'b1;
      if (w_load) begin
        r_shift <= r_full ? r_hold : IDLE_BYTE;
        r_full  <= 1'b0;
      end else begin
        if (w_bit) r_shift <= {r_shift[BITS_PER_CH-2:0], 1'b1};
        if (w_accept) begin
          r_hold <= ch_data;
          r_full <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_st_bus_tx.sv
// tb_st_bus_tx: scoreboard bench for the ST-BUS transmitter at DIV=4
module tb_st_bus_tx;
  localparam logic [10:0] IDLE_OUT = 11'b111_0_00000_0_0;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       ch_valid = 1'b0;
  logic [7:0] ch_data = 8'h00;
  logic       ch_ready;
  logic [4:0] ch_num;
  logic       c4;
  logic       f0;
  logic       dstx;
  logic       frame_start;
  logic       underrun;
  int         n_chk = 0;
  int         n_fail = 0;
  int         k = 0;
  bit         sb_on = 1'b0;
  bit         exp_full = 1'b0;
  logic [7:0] cur = 8'hFF;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  st_bus_tx #(.DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .ch_ready    (ch_ready),
    .ch_num      (ch_num),
    .c4          (c4),
    .f0          (f0),
    .dstx        (dstx),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want summary");
    $fatal(1, "timeout");
  end

  task automatic start();
    sb_on = 1'b0;
    ch_valid = 1'b0;
    en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    exp_q.delete();
    exp_q.push_back(8'hFF);
    exp_full = 1'b0;
    sb_on = 1'b1;
  endtask

  task automatic tick();
    int p;
    logic exp_rdy;
    logic exp_ur;
    logic exp_c4;
    logic exp_f0;
    logic exp_fs;
    logic [4:0] exp_num;
    if (sb_on) begin
      p = k % 64;
      if (p == 0) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_queue k=%0d got empty queue, want a byte for the channel", k);
          cur = 8'hFF;
        end else cur = exp_q.pop_front();
      end
      exp_rdy = k >= 1 && !exp_full && p != 63;
      exp_num = k >= 1 ? 5'((k / 64 + 1) % 32) : 5'd0;
      exp_ur  = p == 63 && !exp_full;
      exp_c4  = (k % 4) < 2;
      exp_f0  = ((k / 4) % 512) != 511;
      exp_fs  = k > 0 && (k % 2048) == 0;
      n_chk++;
      if (ch_ready !== exp_rdy) begin n_fail++; $display("FAIL sb_ready k=%0d got %b want %b", k, ch_ready, exp_rdy); end
      n_chk++;
      if (ch_num !== exp_num) begin n_fail++; $display("FAIL sb_ch_num k=%0d got %0d want %0d", k, ch_num, exp_num); end
      n_chk++;
      if (c4 !== exp_c4) begin n_fail++; $display("FAIL sb_c4 k=%0d got %b want %b", k, c4, exp_c4); end
      n_chk++;
      if (f0 !== exp_f0) begin n_fail++; $display("FAIL sb_f0 k=%0d got %b want %b", k, f0, exp_f0); end
      n_chk++;
      if (frame_start !== exp_fs) begin n_fail++; $display("FAIL sb_frame_start k=%0d got %b want %b", k, frame_start, exp_fs); end
      n_chk++;
      if (underrun !== exp_ur) begin n_fail++; $display("FAIL sb_underrun k=%0d got %b want %b", k, underrun, exp_ur); end
      n_chk++;
      if (dstx !== cur[7 - p / 8]) begin n_fail++; $display("FAIL sb_dstx k=%0d byte %h got %b want %b", k, cur, dstx, cur[7 - p / 8]); end
      if (p == 63) begin
        if (exp_full) exp_full = 1'b0;
        else exp_q.push_back(8'hFF);
      end
      if (ch_valid && exp_rdy) begin
        exp_q.push_back(ch_data);
        exp_full = 1'b1;
      end
    end
    @(negedge clk);
    k++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({c4, f0, dstx, ch_ready, ch_num, frame_start, underrun} !== IDLE_OUT) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want %b", {c4, f0, dstx, ch_ready, ch_num, frame_start, underrun}, IDLE_OUT);
    end
  endtask

  task automatic test_timing();
    int last_fall = -1;
    int last_rise = -1;
    int fs_cnt = 0;
    logic pf0 = 1'b1;
    logic pc4 = 1'b1;
    start();
    for (int i = 0; i < 4300; i++) begin
      if (pf0 && !f0) begin
        if (last_fall >= 0) begin
          n_chk++;
          if (k - last_fall != 2048) begin n_fail++; $display("FAIL f0_period got %0d want 2048", k - last_fall); end
        end
        last_fall = k;
      end
      if (!pf0 && f0) begin
        n_chk++;
        if (k - last_fall != 4) begin n_fail++; $display("FAIL f0_low got %0d want 4", k - last_fall); end
        n_chk++;
        if (frame_start !== 1'b1) begin n_fail++; $display("FAIL fs_align k=%0d got %b want 1", k, frame_start); end
      end
      if (frame_start === 1'b1) fs_cnt++;
      if (!pc4 && c4) begin
        if (last_rise >= 0) begin
          n_chk++;
          if (k - last_rise != 4) begin n_fail++; $display("FAIL c4_period got %0d want 4", k - last_rise); end
        end
        last_rise = k;
      end
      if (pc4 && !c4 && last_rise >= 0) begin
        n_chk++;
        if (k - last_rise != 2) begin n_fail++; $display("FAIL c4_high got %0d want 2", k - last_rise); end
      end
      pf0 = f0;
      pc4 = c4;
      tick();
    end
    n_chk++;
    if (fs_cnt != 2) begin n_fail++; $display("FAIL fs_count got %0d want 2", fs_cnt); end
    n_chk++;
    if (last_fall != 4092) begin n_fail++; $display("FAIL f0_last_fall got %0d want 4092", last_fall); end
  endtask

  task automatic test_pattern();
    logic [7:0] pat = 8'hA5;
    bit fed = 1'b0;
    start();
    for (int i = 0; i < 320; i++) begin
      ch_valid = !fed && ch_num == 5'd5;
      ch_data = pat;
      if (ch_valid && ch_ready) fed = 1'b1;
      tick();
    end
    ch_valid = 1'b0;
    n_chk++;
    if (!fed) begin n_fail++; $display("FAIL a5_accept got no accept want accept with ch_num 5"); end
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < 8; j++) begin
        n_chk++;
        if (dstx !== pat[7 - b]) begin n_fail++; $display("FAIL a5_bit%0d clk%0d got %b want %b", b, j, dstx, pat[7 - b]); end
        tick();
      end
  endtask

  task automatic test_underrun();
    bit [31:0] fed = '0;
    int ur_cnt = 0;
    int ur_k = -1;
    logic [7:0] ff = 8'h00;
    logic [4:0] n;
    logic want;
    start();
    for (int i = 0; i < 2047; i++) begin
      n = ch_num;
      want = n >= 5'd1 && n <= 5'd30 && !fed[n];
      ch_valid = want;
      ch_data = 8'h40 + {3'b000, n};
      if (want && ch_ready) fed[n] = 1'b1;
      if (underrun === 1'b1) begin ur_cnt++; ur_k = k; end
      if (k == 1984) begin
        n_chk++;
        if (ch_num !== 5'd0) begin n_fail++; $display("FAIL ch_num_wrap got %0d want 0", ch_num); end
      end
      if (k >= 1984 && k % 8 == 4) ff = {ff[6:0], dstx};
      tick();
    end
    ch_valid = 1'b0;
    n_chk++;
    if (fed !== 32'h7FFF_FFFE) begin n_fail++; $display("FAIL ur_feed got %h want 7ffffffe", fed); end
    n_chk++;
    if (ur_cnt != 1) begin n_fail++; $display("FAIL ur_count got %0d want 1", ur_cnt); end
    n_chk++;
    if (ur_k != 1983) begin n_fail++; $display("FAIL ur_cycle got %0d want 1983", ur_k); end
    n_chk++;
    if (ff !== 8'hFF) begin n_fail++; $display("FAIL ch31_byte got %h want ff", ff); end
  endtask

  task automatic test_stream();
    int acc[3] = '{0, 0, 0};
    int ur_after = 0;
    int rdy_bad = 0;
    logic a;
    start();
    ch_data = 8'h00;
    for (int i = 0; i < 6144; i++) begin
      ch_valid = 1'b1;
      a = ch_valid && ch_ready;
      if (ch_ready === 1'b1 && k % 64 == 63) rdy_bad++;
      if (a) acc[k / 2048]++;
      if (underrun === 1'b1 && k >= 2048) ur_after++;
      tick();
      if (a) ch_data++;
    end
    ch_valid = 1'b0;
    n_chk++;
    if (rdy_bad != 0) begin n_fail++; $display("FAIL ready_in_load got %0d want 0", rdy_bad); end
    for (int f = 0; f < 3; f++) begin
      n_chk++;
      if (acc[f] != 32) begin n_fail++; $display("FAIL accepts_frame%0d got %0d want 32", f, acc[f]); end
    end
    n_chk++;
    if (ur_after != 0) begin n_fail++; $display("FAIL stream_underrun got %0d want 0", ur_after); end
  endtask

  task automatic test_reset_mid();
    bit fed = 1'b0;
    int ur_cnt = 0;
    int ur_k = -1;
    start();
    for (int i = 0; i < 788; i++) begin
      ch_valid = !fed && ch_num == 5'd13;
      ch_data = 8'h3C;
      if (ch_valid && ch_ready) fed = 1'b1;
      tick();
    end
    ch_valid = 1'b0;
    n_chk++;
    if (!fed || ch_ready !== 1'b0) begin n_fail++; $display("FAIL hold_full got fed=%b ready=%b want fed=1 ready=0", fed, ch_ready); end
    sb_on = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({c4, f0, dstx, ch_ready, ch_num, frame_start, underrun} !== IDLE_OUT) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got %b want %b", {c4, f0, dstx, ch_ready, ch_num, frame_start, underrun}, IDLE_OUT);
    end
    start();
    for (int i = 0; i < 130; i++) begin
      if (underrun === 1'b1 && k <= 100) begin ur_cnt++; ur_k = k; end
      tick();
    end
    n_chk++;
    if (ur_cnt != 1 || ur_k != 63) begin n_fail++; $display("FAIL held_byte_lost got %0d pulses at %0d want 1 at 63", ur_cnt, ur_k); end
  endtask

  task automatic test_en_drop();
    int lowk = -1;
    start();
    for (int i = 0; i < 700; i++) tick();
    sb_on = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_chk++;
      if ({c4, f0, dstx, ch_ready, ch_num, frame_start, underrun} !== IDLE_OUT) begin
        n_fail++;
        $display("FAIL en_idle clk%0d got %b want %b", i, {c4, f0, dstx, ch_ready, ch_num, frame_start, underrun}, IDLE_OUT);
      end
    end
    en = 1'b1;
    k = 0;
    exp_q.delete();
    exp_q.push_back(8'hFF);
    exp_full = 1'b0;
    sb_on = 1'b1;
    for (int i = 0; i < 2100; i++) begin
      if (f0 === 1'b0 && lowk < 0) lowk = k;
      tick();
    end
    n_chk++;
    if (lowk != 2044) begin n_fail++; $display("FAIL en_rise_f0 got %0d want 2044", lowk); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_pattern();
    test_underrun();
    test_stream();
    test_reset_mid();
    test_en_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
